// File: rtl/hxm_event_sequencer_pkg.sv
// Shared widths and state encoding for the hxmpp event sequencer.
// Default widths track the project parameter file.
package hxm_event_sequencer_pkg;

  localparam int SSIDBITS    = 8;
  localparam int HITINFOBITS = 8;
  localparam int MAXHITNBITS = 3;
  localparam int NCOLS_HIM   = 4;
  localparam int HITBUS_BITS = NCOLS_HIM * HITINFOBITS;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_WRITE  = 3'd1,
    ST_GAP    = 3'd2,
    ST_REQ    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESULT = 3'd5,
    ST_DONE   = 3'd6
  } seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hxm_cycle_counter.sv
// Loadable down-counter that parks at zero; last flags the final counted cycle.
module hxm_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/hxm_event_sequencer.sv
// Per-event controller owning every hxmpp control pin: clear, write hits,
// settle gap, then one-at-a-time SSID readback with timeout fillers.
module hxm_event_sequencer
  import hxm_event_sequencer_pkg::*;
#(
  parameter int SSID_W       = SSIDBITS,
  parameter int HITINFO_W    = HITINFOBITS,
  parameter int NHITS_W      = MAXHITNBITS,
  parameter int HITBUS_W     = HITBUS_BITS,
  parameter int MAX_HITS     = 64,
  parameter int CLEAR_CYCLES = 4,
  parameter int WR2RD_GAP    = 8,
  parameter int READ_TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hit_valid,
  output logic                 hit_ready,
  input  logic [SSID_W-1:0]    hit_ssid,
  input  logic [HITINFO_W-1:0] hit_info,
  input  logic                 hit_last,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SSID_W-1:0]    req_ssid,
  input  logic                 req_last,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SSID_W-1:0]    res_ssid,
  output logic                 res_hit,
  output logic [NHITS_W-1:0]   res_nhits,
  output logic [HITBUS_W-1:0]  res_info,
  output logic                 res_timeout,
  output logic                 hxm_reset,
  output logic                 hxm_write,
  output logic [SSID_W-1:0]    hxm_write_ssid,
  output logic [HITINFO_W-1:0] hxm_write_info,
  output logic                 hxm_read,
  output logic [SSID_W-1:0]    hxm_read_ssid,
  input  logic                 hxm_read_finished,
  input  logic [SSID_W-1:0]    hxm_ssid_read,
  input  logic                 hxm_hit_this_event,
  input  logic [NHITS_W-1:0]   hxm_nhits,
  input  logic [HITBUS_W-1:0]  hxm_hitinfo,
  output logic                 event_done,
  output logic [15:0]          event_count,
  output logic                 err_overflow,
  output logic                 err_timeout
);

  localparam int CNT_W = $clog2(max3(CLEAR_CYCLES, WR2RD_GAP, READ_TIMEOUT) + 1);
  localparam int HC_W  = $clog2(MAX_HITS + 1);

  seq_state_t        state;
  logic [HC_W-1:0]   hit_cnt;
  logic              last_req;
  logic              ctr_load;
  logic [CNT_W-1:0]  ctr_val;
  logic [CNT_W-1:0]  ctr_count;
  logic              ctr_last;

  hxm_cycle_counter #(.W(CNT_W)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (ctr_val),
    .count    (ctr_count),
    .last     (ctr_last)
  );

  // A zero count in CLEAR only happens straight out of reset; arm it there.
  always_comb begin
    ctr_load = 1'b0;
    ctr_val  = '0;
    case (state)
      ST_CLEAR: if (ctr_count == '0) begin
        ctr_load = 1'b1;
        ctr_val  = CNT_W'(CLEAR_CYCLES);
      end
      ST_WRITE: if (hit_ready && hit_valid && hit_last) begin
        ctr_load = 1'b1;
        ctr_val  = CNT_W'(WR2RD_GAP);
      end
      ST_REQ: if (req_ready && req_valid) begin
        ctr_load = 1'b1;
        ctr_val  = CNT_W'(READ_TIMEOUT);
      end
      ST_DONE: begin
        ctr_load = 1'b1;
        ctr_val  = CNT_W'(CLEAR_CYCLES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_CLEAR;
      hxm_reset      <= 1'b1;
      hit_ready      <= 1'b0;
      req_ready      <= 1'b0;
      hxm_write      <= 1'b0;
      hxm_write_ssid <= '0;
      hxm_write_info <= '0;
      hxm_read       <= 1'b0;
      hxm_read_ssid  <= '0;
      res_valid      <= 1'b0;
      res_ssid       <= '0;
      res_hit        <= 1'b0;
      res_nhits      <= '0;
      res_info       <= '0;
      res_timeout    <= 1'b0;
      event_done     <= 1'b0;
      event_count    <= '0;
      err_overflow   <= 1'b0;
      err_timeout    <= 1'b0;
      hit_cnt        <= '0;
      last_req       <= 1'b0;
    end else begin
      hxm_write  <= 1'b0;
      hxm_read   <= 1'b0;
      event_done <= 1'b0;
      case (state)
        ST_CLEAR: begin
          hit_cnt <= '0;
          if (ctr_last) begin
            state     <= ST_WRITE;
            hxm_reset <= 1'b0;
            hit_ready <= 1'b1;
          end
        end
        ST_WRITE: if (hit_valid) begin
          // Past MAX_HITS the beat is still consumed so upstream never stalls.
          if (hit_cnt != HC_W'(MAX_HITS)) begin
            hxm_write      <= 1'b1;
            hxm_write_ssid <= hit_ssid;
            hxm_write_info <= hit_info;
            hit_cnt        <= hit_cnt + 1'b1;
          end else begin
            err_overflow <= 1'b1;
          end
          if (hit_last) begin
            state     <= ST_GAP;
            hit_ready <= 1'b0;
          end
        end
        ST_GAP: if (ctr_last) begin
          state     <= ST_REQ;
          req_ready <= 1'b1;
        end
        ST_REQ: if (req_valid) begin
          req_ready     <= 1'b0;
          hxm_read      <= 1'b1;
          hxm_read_ssid <= req_ssid;
          last_req      <= req_last;
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          if (hxm_read_finished) begin
            res_ssid    <= hxm_ssid_read;
            res_hit     <= hxm_hit_this_event;
            res_nhits   <= hxm_nhits;
            res_info    <= hxm_hitinfo;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= ST_RESULT;
          end else if (ctr_last) begin
            res_ssid    <= hxm_read_ssid;
            res_hit     <= 1'b0;
            res_nhits   <= '0;
            res_info    <= '0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            err_timeout <= 1'b1;
            state       <= ST_RESULT;
          end
        end
        ST_RESULT: if (res_ready) begin
          res_valid <= 1'b0;
          if (last_req) begin
            state       <= ST_DONE;
            event_done  <= 1'b1;
            event_count <= event_count + 16'd1;
          end else begin
            state     <= ST_REQ;
            req_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_CLEAR;
          hxm_reset <= 1'b1;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_hxm_event_sequencer.sv
// Directed bench for hxm_event_sequencer with a small hxmpp readback responder.
module tb_hxm_event_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hit_valid = 1'b0, hit_last = 1'b0;
  logic [7:0]  hit_ssid = '0, hit_info = '0;
  logic        req_valid = 1'b0, req_last = 1'b0;
  logic [7:0]  req_ssid = '0;
  logic        res_ready = 1'b0;
  logic        hit_ready, req_ready, res_valid, res_hit, res_timeout;
  logic [7:0]  res_ssid;
  logic [2:0]  res_nhits;
  logic [31:0] res_info;
  logic        hxm_reset, hxm_write, hxm_read;
  logic [7:0]  hxm_write_ssid, hxm_write_info, hxm_read_ssid;
  logic        hxm_read_finished = 1'b0;
  logic [7:0]  hxm_ssid_read = '0;
  logic        hxm_hit_this_event = 1'b0;
  logic [2:0]  hxm_nhits = '0;
  logic [31:0] hxm_hitinfo = '0;
  logic        event_done, err_overflow, err_timeout;
  logic [15:0] event_count;

  int tests = 0;
  int fails = 0;
  logic       model_on = 1'b0;
  int         pend = 0;
  logic [7:0] pend_ssid = '0;

  hxm_event_sequencer dut (
    .clk(clk), .reset(reset),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_ssid(hit_ssid),
    .hit_info(hit_info), .hit_last(hit_last),
    .req_valid(req_valid), .req_ready(req_ready), .req_ssid(req_ssid),
    .req_last(req_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_ssid(res_ssid),
    .res_hit(res_hit), .res_nhits(res_nhits), .res_info(res_info),
    .res_timeout(res_timeout),
    .hxm_reset(hxm_reset), .hxm_write(hxm_write),
    .hxm_write_ssid(hxm_write_ssid), .hxm_write_info(hxm_write_info),
    .hxm_read(hxm_read), .hxm_read_ssid(hxm_read_ssid),
    .hxm_read_finished(hxm_read_finished), .hxm_ssid_read(hxm_ssid_read),
    .hxm_hit_this_event(hxm_hit_this_event), .hxm_nhits(hxm_nhits),
    .hxm_hitinfo(hxm_hitinfo),
    .event_done(event_done), .event_count(event_count),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Responder: finished pulses 3 cycles after each read; nHits 7 for SSID 0x44, else 3.
  always @(posedge clk) begin
    #1;
    hxm_read_finished = 1'b0;
    if (hxm_read && model_on) begin
      pend      = 3;
      pend_ssid = hxm_read_ssid;
    end else if (pend != 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        hxm_read_finished  = 1'b1;
        hxm_ssid_read      = pend_ssid;
        hxm_hit_this_event = 1'b1;
        hxm_nhits          = (pend_ssid == 8'h44) ? 3'd7 : 3'd3;
        hxm_hitinfo        = {4{pend_ssid}};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] s;

    // Reset and first clear window
    tick(); tick();
    chk("rst_hxm_reset", hxm_reset, 1);
    chk("rst_hit_ready", hit_ready, 0);
    chk("rst_event_count", event_count, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_errs", {err_overflow, err_timeout}, 0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("clear_hold", {hxm_reset, hit_ready}, 2'b10);
    end
    tick();
    chk("clear_exit", {hxm_reset, hit_ready}, 2'b01);

    // Event 1: 23 hits, each written one cycle after accept
    for (int i = 0; i < 23; i++) begin
      s = 8'h88 - 8'(3 * i);
      hit_valid = 1'b1; hit_ssid = s; hit_info = s; hit_last = (i == 22);
      tick();
      chk("wr_pulse", hxm_write, 1);
      chk("wr_ssid", hxm_write_ssid, s);
      chk("wr_info", hxm_write_info, s);
      chk("wr_hit_ready", hit_ready, (i != 22));
    end
    hit_valid = 1'b0; hit_last = 1'b0;
    chk("gap_first", req_ready, 0);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("gap_idle", {req_ready, hxm_write}, 0);
    end
    tick();
    chk("gap_end_req_ready", req_ready, 1);

    // Read 0x44 with a held-off consumer
    model_on = 1'b1;
    req_valid = 1'b1; req_ssid = 8'h44; req_last = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("rd1_pulse", {hxm_read, hxm_read_ssid}, {1'b1, 8'h44});
    chk("rd1_req_ready", req_ready, 0);
    tick(); tick(); tick();
    chk("rd1_not_yet", res_valid, 0);
    tick();
    chk("rd1_valid", res_valid, 1);
    chk("rd1_fields", {res_ssid, res_hit, res_nhits, res_info, res_timeout},
        {8'h44, 1'b1, 3'd7, 32'h44444444, 1'b0});
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_res", {res_valid, res_ssid, res_nhits}, {1'b1, 8'h44, 3'd7});
      chk("hold_noreq", {req_ready, hxm_read}, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("rd1_release", {res_valid, req_ready}, 2'b01);

    // Read 0x88 as last of event
    req_valid = 1'b1; req_ssid = 8'h88; req_last = 1'b1;
    tick();
    req_valid = 1'b0; req_last = 1'b0;
    chk("rd2_pulse", {hxm_read, hxm_read_ssid}, {1'b1, 8'h88});
    tick(); tick(); tick(); tick();
    chk("rd2_fields", {res_valid, res_ssid, res_hit, res_nhits, res_timeout},
        {1'b1, 8'h88, 1'b1, 3'd3, 1'b0});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("ev1_done", {event_done, event_count}, {1'b1, 16'd1});
    tick();
    chk("ev1_clear", {event_done, hxm_reset, hit_ready}, 3'b010);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ev2_clear_hold", hxm_reset, 1);
    end
    tick();
    chk("ev2_write", {hxm_reset, hit_ready}, 2'b01);

    // Event 2: 66 hits overflow the 64-hit limit
    for (int i = 0; i < 66; i++) begin
      hit_valid = 1'b1; hit_ssid = 8'(i); hit_info = ~8'(i); hit_last = (i == 65);
      tick();
      chk("ovf_write", hxm_write, (i < 64));
      chk("ovf_flag", err_overflow, (i >= 64));
    end
    hit_valid = 1'b0; hit_last = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("ev2_req_ready", req_ready, 1);

    // Timeout: responder silent
    model_on = 1'b0;
    req_valid = 1'b1; req_ssid = 8'h5C; req_last = 1'b1;
    tick();
    req_valid = 1'b0; req_last = 1'b0;
    chk("to_read", hxm_read, 1);
    for (int k = 0; k < 31; k++) tick();
    chk("to_not_yet", {res_valid, err_timeout}, 0);
    tick();
    chk("to_fields", {res_valid, res_ssid, res_hit, res_nhits, res_info, res_timeout},
        {1'b1, 8'h5C, 1'b0, 3'd0, 32'd0, 1'b1});
    chk("to_err", err_timeout, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("ev2_done", {event_done, event_count}, {1'b1, 16'd2});
    tick();
    chk("ev3_sticky", {hxm_reset, err_timeout, err_overflow}, 3'b111);
    for (int k = 0; k < 4; k++) tick();
    chk("ev3_write", hit_ready, 1);

    // Event 3: one hit, reach REQ, then reset aborts
    hit_valid = 1'b1; hit_ssid = 8'h11; hit_info = 8'h22; hit_last = 1'b1;
    tick();
    hit_valid = 1'b0; hit_last = 1'b0;
    chk("ev3_wr", {hxm_write, hxm_write_ssid, hxm_write_info}, {1'b1, 8'h11, 8'h22});
    for (int k = 0; k < 8; k++) tick();
    chk("ev3_req", {req_ready, err_timeout}, 2'b11);
    reset = 1'b0;
    tick();
    chk("abort_state", {hxm_reset, req_ready, hit_ready, res_valid}, 4'b1000);
    chk("abort_flags", {err_overflow, err_timeout, event_count}, 18'd0);
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
